// File: rtl/seg_sum_checker.sv
// Sweeps all 16 2-bit operand pairs into an adder under test and checks its
// seven-segment result. Optional macro CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module seg_sum_checker #(
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] segt,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] ab_q, ab_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] dec_val;
  logic       dec_ok;
  logic [2:0] sum;
  logic       mism;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 3'd0;
    case (segt)
      7'h3F: dec_val = 3'd0;
      7'h06: dec_val = 3'd1;
      7'h5B: dec_val = 3'd2;
      7'h4F: dec_val = 3'd3;
      7'h66: dec_val = 3'd4;
      7'h6D: dec_val = 3'd5;
      7'h7D: dec_val = 3'd6;
      default: dec_ok = 1'b0;
    endcase
  end

  assign sum  = {1'b0, ab_q[3:2]} + {1'b0, ab_q[1:0]};
  assign mism = !dec_ok || (dec_val != sum);

  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ab_d    = 4'd0;
          err_d   = 5'd0;
          pass_d  = 1'b0;
          cnt_d   = RELOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (mism && err_q != 5'd16) err_d = err_q + 5'd1;
`ifdef CHK_STOP_ON_FAIL_EN
        if (mism || ab_q == 4'hF) begin
`else
        if (ab_q == 4'hF) begin
`endif
          state_d = DONE;
          // pass is resolved here so it is visible together with the done pulse
          pass_d  = (err_d == 5'd0);
        end else begin
          ab_d    = ab_q + 4'd1;
          cnt_d   = RELOAD;
          state_d = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ab_q    <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A         = ab_q[3:2];
  assign B         = ab_q[1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_seg_sum_checker.sv
// Directed bench for seg_sum_checker: behavioural adder/display model with fault modes.
module tb_seg_sum_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] segt;
  logic [1:0] A, B;
  logic       busy, done, pass;
  logic [4:0] err_count;

  int errors = 0;
  int checks = 0;
  int mode   = 0;   // 0 correct, 1 stuck at 0, 2 wrong only for 3+3

  seg_sum_checker #(.SETTLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .segt(segt),
    .A(A), .B(B), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: enc = 7'h3F;
      1: enc = 7'h06;
      2: enc = 7'h5B;
      3: enc = 7'h4F;
      4: enc = 7'h66;
      5: enc = 7'h6D;
      6: enc = 7'h7D;
      default: enc = 7'h00;
    endcase
  endfunction

  always_comb begin
    segt = enc(int'(A) + int'(B));
    if (mode == 1) segt = 7'h00;
    else if (mode == 2 && A == 2'd3 && B == 2'd3) segt = 7'h6D;
  end

  // Cycle c = c-th falling edge after the edge that accepts start.
  task automatic run_sweep(input int repulse, output int done_cyc,
                           output int busy_cyc, output int order_err);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_cyc = -1; busy_cyc = 0; order_err = 0;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = (c == repulse);
      if (busy) begin
        busy_cyc++;
        if ({A, B} != 4'((c - 1) / 5)) order_err++;
      end
      if (done) done_cyc = c;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({A, B, busy, done, pass, err_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%0d B=%0d busy=%b done=%b pass=%b err=%0d, want all 0",
               A, B, busy, done, pass, err_count);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_correct();
    int dc, bc, oe;
    mode = 0;
    run_sweep(0, dc, bc, oe);
    checks++;
    if (dc != 81) begin errors++; $display("FAIL correct_done_cycle: got %0d want 81", dc); end
    checks++;
    if (bc != 80) begin errors++; $display("FAIL correct_busy_cycles: got %0d want 80", bc); end
    checks++;
    if (oe != 0) begin errors++; $display("FAIL correct_sweep_order: %0d out-of-order cycles want 0", oe); end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0) begin
      errors++; $display("FAIL correct_result: pass=%b err=%0d want 1 0", pass, err_count);
    end
    checks++;
    if (A !== 2'd3 || B !== 2'd3) begin
      errors++; $display("FAIL correct_final_ab: A=%0d B=%0d want 3 3", A, B);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL correct_idle_hold: done=%b busy=%b pass=%b err=%0d want 0 0 1 0",
               done, busy, pass, err_count);
    end
  endtask

  task automatic test_stuck();
    int dc, bc, oe;
    mode = 1;
    run_sweep(0, dc, bc, oe);
`ifdef CHK_STOP_ON_FAIL_EN
    checks++;
    if (dc != 6) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 6", dc); end
    checks++;
    if (err_count !== 5'd1 || pass !== 1'b0) begin
      errors++; $display("FAIL stuck_result: err=%0d pass=%b want 1 0", err_count, pass);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (A !== 2'd0 || B !== 2'd0) begin
      errors++; $display("FAIL stuck_hold_ab: A=%0d B=%0d want 0 0", A, B);
    end
`else
    checks++;
    if (dc != 81) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 81", dc); end
    checks++;
    if (err_count !== 5'd16 || pass !== 1'b0) begin
      errors++; $display("FAIL stuck_result: err=%0d pass=%b want 16 0", err_count, pass);
    end
`endif
    mode = 0;
  endtask

  task automatic test_single_fault();
    int dc, bc, oe;
    mode = 2;
    run_sweep(0, dc, bc, oe);
    checks++;
    if (dc != 81) begin errors++; $display("FAIL single_done_cycle: got %0d want 81", dc); end
    checks++;
    if (err_count !== 5'd1 || pass !== 1'b0) begin
      errors++; $display("FAIL single_result: err=%0d pass=%b want 1 0", err_count, pass);
    end
    mode = 0;
  endtask

  task automatic test_start_ignored();
    int dc, bc, oe;
    mode = 0;
    run_sweep(20, dc, bc, oe);
    checks++;
    if (dc != 81 || bc != 80 || oe != 0) begin
      errors++;
      $display("FAIL restart_ignored: done=%0d busy=%0d order_err=%0d want 81 80 0", dc, bc, oe);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0) begin
      errors++; $display("FAIL restart_result: pass=%b err=%0d want 1 0", pass, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0, busy_seen = 0;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({A, B, busy, done, pass, err_count} !== 11'd0) begin
      errors++;
      $display("FAIL midreset_outputs: A=%0d B=%0d busy=%b done=%b pass=%b err=%0d want all 0",
               A, B, busy, done, pass, err_count);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checks++;
    if (done_seen != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL midreset_no_resume: done cycles=%0d busy cycles=%0d want 0 0", done_seen, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck();
    test_single_fault();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_sum_checker.md
SEG_SUM_CHECKER -- requirements
Module: seg_sum_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles operands are held before segt is sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 segt  input  7  seven-segment pattern returned by the adder under test, {g,f,e,d,c,b,a}, active-high (1 = lit).
REQ-006 A  output  2  operand A driven to the adder; registered.
REQ-007 B  output  2  operand B driven to the adder; registered.
REQ-008 busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE).
REQ-009 done  output  1  single-cycle pulse marking sweep completion.
REQ-010 pass  output  1  high when the last completed sweep had zero mismatches; held until the next accepted start.
REQ-011 err_count  output  5  mismatch count of the current or last sweep, 0..16.

Function
REQ-012 FSM states are IDLE, SETTLE, SAMPLE and DONE.
REQ-013 IDLE with start=1: A=0, B=0, err_count=0, pass=0, settle counter=SETTLE_CYC-1, go to SETTLE.
REQ-014 SETTLE: counter decrements each cycle; at 0 go to SAMPLE; state lasts exactly SETTLE_CYC cycles.
REQ-015 SAMPLE lasts one cycle: decode segt; compare the decoded value with the zero-extended A+B (0..6).
REQ-016 Decode table is 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D; any other pattern is invalid and counts as a mismatch.
REQ-017 On a mismatch, err_count increments by 1 in the SAMPLE cycle and saturates at 16.
REQ-018 After SAMPLE with {A,B}!=4'hF: {A,B} increments as one 4-bit value (A major, B minor, order 00/00, 00/01 ... 11/11), counter reloads, go to SETTLE.
REQ-019 After SAMPLE with {A,B}==4'hF: go to DONE; A and B hold 2'b11.
REQ-020 DONE lasts one cycle: done=1, pass=(err_count==0); next state is IDLE.
REQ-021 Timing: done is high exactly 16*(SETTLE_CYC+1)+1 cycles after the clock edge that accepts start (81 cycles for the default).
REQ-022 start is ignored in SETTLE, SAMPLE and DONE; no restart occurs and no state is disturbed.
REQ-023 err_count and pass hold their values in IDLE until the next accepted start.
REQ-024 All outputs are registered; no combinational path from segt to any output.

Reset
REQ-025 rst=1 forces IDLE immediately: A=0, B=0, busy=0, done=0, pass=0, err_count=0, counter=0.
REQ-026 Reset asserted mid-sweep aborts the sweep; no done pulse follows; a new start is required after release.

Configuration
REQ-027 Macro CHK_STOP_ON_FAIL_EN defined: the first mismatch in SAMPLE goes straight to DONE (err_count=1, pass=0); A and B hold the failing vector until the next start.
REQ-028 CHK_STOP_ON_FAIL_EN undefined: all 16 vectors are always swept, per REQ-018/REQ-019.

Verification
REQ-029 Correct adder model, SETTLE_CYC=4, start pulse -> busy 80 cycles, done at cycle 81, pass=1, err_count=0, all 16 {A,B} combinations observed in sweep order.
REQ-030 Model stuck at segt=7'h00 -> done, pass=0, err_count=16.
REQ-031 Model returns 7'h6D only for A=3,B=3 (correct otherwise) -> err_count=1, pass=0.
REQ-032 start re-pulsed at cycle 20 of the sweep -> ignored, done still at cycle 81; rst pulsed at cycle 30 of a second sweep -> all outputs at reset values, no done pulse.
REQ-033 CHK_STOP_ON_FAIL_EN defined, stuck model -> done 6 cycles after start, err_count=1, pass=0, A=0, B=0 held.
